// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive/transmit types, framing constants and parity helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP} rx_state_t;
  localparam int FRAME_BITS = 9;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  function automatic logic parity_err(input logic [FRAME_BITS-1:0] v, input logic odd);
    return ^v ^ odd;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered full/empty derived from occupancy count
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];
  // next occupancy; a simultaneous push and pop leaves it unchanged
  always_comb count_n = (do_push & ~do_pop) ? count + 1'b1 : (~do_push & do_pop) ? count - 1'b1 : count;
  // storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at the power-of-two depth; flags track the new count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count_n;
      full <= count_n == CW'(DEPTH);
      empty <= count_n == '0;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART frame deserialiser with parity/stop checking feeding a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH_R = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       parity_out,
  output logic       PREADY_R,
  output logic       rd_err,
  output logic       Rx_ready,
  output logic       RxFF,
  output logic       RxFE,
  output logic       frame_err,
  output logic       overrun_err
);
  rx_state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [8:0] head;
  logic push, pop_ok, writable, frame_set, ovr_set;
  assign pop_ok = rd_en & ~RxFE;
  assign writable = ~RxFF | pop_ok;
  assign Rx_ready = ~RxFF;
  uart_sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH_R)) u_fifo (
    .clk(baud_clk),
    .rst(rst),
    .push(push),
    .pop(pop_ok),
    .wr_data({parity_err(shreg, ODD_PARITY), shreg[7:0]}),
    .rd_data(head),
    .full(RxFF),
    .empty(RxFE)
  );
  // deserialiser next state; the frame is judged on the stop-bit cycle
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    push = 1'b0;
    frame_set = 1'b0;
    ovr_set = 1'b0;
    case (state)
      IDLE: begin
        state_n = serial_in == START_LVL ? DATA : IDLE;
        bit_cnt_n = '0;
      end
      DATA: begin
        shreg_n[bit_cnt] = serial_in;
        bit_cnt_n = bit_cnt + 1'b1;
        state_n = bit_cnt == 4'(FRAME_BITS - 1) ? STOP : DATA;
      end
      STOP: begin
        state_n = IDLE;
        push = serial_in == STOP_LVL && writable;
        ovr_set = serial_in == STOP_LVL && !writable;
        frame_set = serial_in != STOP_LVL;
      end
      default: state_n = IDLE;
    endcase
  end
  // deserialiser state register; reset discards any partial frame
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
    end
  end
  // APB-side pop response and sticky error flags; a new error beats clr_err
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      data_out <= '0;
      parity_out <= 1'b0;
      PREADY_R <= 1'b0;
      rd_err <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      data_out <= pop_ok ? head[7:0] : data_out;
      parity_out <= pop_ok ? head[8] : parity_out;
      PREADY_R <= rd_en;
      rd_err <= rd_en & RxFE;
      frame_err <= frame_set | (frame_err & ~clr_err);
      overrun_err <= ovr_set | (overrun_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random frames checked against a queue-based receive model
module tb_uart_rx_fifo;
  logic baud_clk = 1'b0;
  logic rst, serial_in, rd_en, clr_err;
  logic [7:0] data_out;
  logic parity_out, PREADY_R, rd_err, Rx_ready, RxFF, RxFE, frame_err, overrun_err;
  int errors = 0;
  int checks = 0;
  logic [8:0] q[$];
  logic m_ferr, m_oerr, m_par, m_rderr;
  logic [7:0] m_data;
  bit pend_pop;

  uart_rx_fifo dut (
    .baud_clk(baud_clk),
    .rst(rst),
    .serial_in(serial_in),
    .rd_en(rd_en),
    .clr_err(clr_err),
    .data_out(data_out),
    .parity_out(parity_out),
    .PREADY_R(PREADY_R),
    .rd_err(rd_err),
    .Rx_ready(Rx_ready),
    .RxFF(RxFF),
    .RxFE(RxFE),
    .frame_err(frame_err),
    .overrun_err(overrun_err)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_pop();
    if (q.size() == 0) m_rderr = 1'b1;
    else begin
      m_rderr = 1'b0;
      {m_par, m_data} = q.pop_front();
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    if (!s) m_ferr = 1'b1;
    else if (q.size() < 16) q.push_back({1'($countones({p, d}) % 2), d});
    else m_oerr = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_RxFE"}, RxFE, q.size() == 0);
    chk({tag, "_RxFF"}, RxFF, q.size() == 16);
    chk({tag, "_Rx_ready"}, Rx_ready, q.size() != 16);
    chk({tag, "_frame_err"}, frame_err, m_ferr);
    chk({tag, "_overrun_err"}, overrun_err, m_oerr);
  endtask

  task automatic check_pop(input string tag);
    chk({tag, "_PREADY_R"}, PREADY_R, 1);
    chk({tag, "_rd_err"}, rd_err, m_rderr);
    chk({tag, "_data_out"}, data_out, m_data);
    chk({tag, "_parity_out"}, parity_out, m_par);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop);
    logic [10:0] b;
    b = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge baud_clk);
      serial_in = b[i];
      rd_en = pop && i == 10;
    end
    if (pop) model_pop();
    model_frame(d, p, s);
    pend_pop = pop;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge baud_clk);
    serial_in = 1'b1;
    rd_en = 1'b0;
    if (pend_pop) check_pop(tag);
    pend_pop = 1'b0;
    check_flags(tag);
  endtask

  task automatic pop(input string tag);
    @(negedge baud_clk);
    serial_in = 1'b1;
    rd_en = 1'b1;
    model_pop();
    @(negedge baud_clk);
    rd_en = 1'b0;
    check_pop(tag);
    check_flags(tag);
  endtask

  task automatic clear(input string tag);
    @(negedge baud_clk);
    clr_err = 1'b1;
    @(negedge baud_clk);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_oerr = 1'b0;
    check_flags(tag);
  endtask

  task automatic do_reset();
    @(negedge baud_clk);
    rst = 1'b1;
    serial_in = 1'b1;
    rd_en = 1'b0;
    clr_err = 1'b0;
    @(negedge baud_clk);
    rst = 1'b0;
    q.delete();
    m_ferr = 1'b0;
    m_oerr = 1'b0;
    m_data = '0;
    m_par = 1'b0;
    pend_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    rd_en = 1'b0;
    clr_err = 1'b0;
    do_reset();
    chk("rst_data_out", data_out, 0);
    chk("rst_parity_out", parity_out, 0);
    chk("rst_PREADY_R", PREADY_R, 0);
    chk("rst_rd_err", rd_err, 0);
    check_flags("rst");
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle_chk("t1_frame");
    pop("t1_pop");
    chk("t1_data_lit", data_out, 8'hA5);
    @(negedge baud_clk);
    chk("t1_pready_pulse", PREADY_R, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    idle_chk("t2_frame");
    pop("t2_pop");
    chk("t2_par_lit", parity_out, 1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle_chk("t3_frame");
    chk("t3_ferr_lit", frame_err, 1);
    clear("t3_clr");
    for (int i = 0; i < 16; i++) send_frame(8'(i), ^8'(i), 1'b1, 1'b0);
    idle_chk("t4_fill");
    chk("t4_full_lit", RxFF, 1);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    idle_chk("t4_ovr");
    chk("t4_ovr_lit", overrun_err, 1);
    for (int i = 0; i < 16; i++) pop("t4_drain");
    pop("t4_empty");
    clear("t4_clr");
    for (int i = 0; i < 16; i++) send_frame(8'(16 + i), 1'b0, 1'b1, 1'b0);
    idle_chk("t5_fill");
    send_frame(8'h99, 1'b0, 1'b1, 1'b1);
    idle_chk("t5_pushpop");
    chk("t5_no_ovr_lit", overrun_err, 0);
    for (int i = 0; i < 16; i++) pop("t5_drain");
    chk("t5_last_lit", data_out, 8'h99);
    @(negedge baud_clk);
    serial_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge baud_clk);
      serial_in = i == 0;
    end
    do_reset();
    check_flags("t6_rst");
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
    idle_chk("t6_frame");
    pop("t6_pop");
    chk("t6_data_lit", data_out, 8'h7E);
    pop("t6_empty");
    chk("t6_rderr_lit", rd_err, 1);
    send_frame(8'h42, 1'b0, 1'b1, 1'b1);
    idle_chk("t6_empty_pushpop");
    pop("t6_after");
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r < 3) begin
        send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
        idle_chk("rnd_frame");
      end else if (r < 5) pop("rnd_pop");
      else clear("rnd_clr");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
